// File: rtl/scoreboard_register_file_pkg.sv
// scoreboard_register_file_pkg: immediate-write type encodings shared by the register file and its bench.
package scoreboard_register_file_pkg;
   typedef enum logic [1:0] {
      IT_TOP      = 2'b00,
      IT_BOTTOM   = 2'b01,
      IT_SIGNED   = 2'b10,
      IT_UNSIGNED = 2'b11
   } imm_type_t;
endpackage

// File: rtl/scoreboard_register_file_register_scoreboard.sv
// register_scoreboard: per-register pending bits, their population count and reserve/clear arbitration.
module register_scoreboard
   import scoreboard_register_file_pkg::*;
#(
   parameter int REG_COUNT = 16,
   localparam int IW = $clog2(REG_COUNT)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 load_write,
   input  logic [IW-1:0]        load_index,
   input  logic                 reserve,
   input  logic [IW-1:0]        reserve_index,
   output logic [REG_COUNT-1:0] busy_mask,
   output logic [IW:0]          busy_count,
   output logic                 reserve_conflict
);
   logic [REG_COUNT-1:0] next_mask;
   logic [IW:0]          next_count;
   logic                 clear_hit;
   assign clear_hit        = load_write && load_index == reserve_index;
   assign reserve_conflict = reserve && busy_mask[reserve_index] && !clear_hit;
   // a reserve applied after the clear keeps the bit set when both hit one index
   always_comb begin
      next_mask = busy_mask;
      if (load_write) next_mask[load_index] = 1'b0;
      if (reserve && !reserve_conflict) next_mask[reserve_index] = 1'b1;
      next_count = '0;
      for (int i = 0; i < REG_COUNT; i++) next_count = next_count + (IW+1)'(next_mask[i]);
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         busy_mask  <= '0;
         busy_count <= '0;
      end else begin
         busy_mask  <= next_mask;
         busy_count <= next_count;
      end
endmodule

// File: rtl/scoreboard_register_file.sv
// scoreboard_register_file: register storage with ALU/immediate and load write ports, read forwarding
// and a pending-load scoreboard.
module scoreboard_register_file
   import scoreboard_register_file_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 16,
   parameter int READ_PORTS = 3,
   localparam int IW = $clog2(REG_COUNT),
   localparam int HW = DATA_WIDTH / 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         write,
   input  logic                         write_immediate,
   input  logic [IW-1:0]                write_index,
   input  logic [DATA_WIDTH-1:0]        write_data,
   input  logic [HW-1:0]                write_immediate_data,
   input  logic [1:0]                   write_immediate_type,
   input  logic                         load_write,
   input  logic [IW-1:0]                load_index,
   input  logic [DATA_WIDTH-1:0]        load_data,
   input  logic                         reserve,
   input  logic [IW-1:0]                reserve_index,
   input  logic [READ_PORTS*IW-1:0]     read_index,
   output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
   output logic [READ_PORTS-1:0]        read_busy,
   output logic [REG_COUNT-1:0]         busy_mask,
   output logic [IW:0]                  busy_count,
   output logic                         reserve_conflict,
   output logic                         write_conflict
);
   logic [DATA_WIDTH-1:0] regs [REG_COUNT];
   logic [DATA_WIDTH-1:0] current, merged;
   logic                  request, accept;
   imm_type_t             imm_type;
   register_scoreboard #(.REG_COUNT(REG_COUNT)) scoreboard (
      .clock(clock),
      .reset(reset),
      .load_write(load_write),
      .load_index(load_index),
      .reserve(reserve),
      .reserve_index(reserve_index),
      .busy_mask(busy_mask),
      .busy_count(busy_count),
      .reserve_conflict(reserve_conflict)
   );
   assign request        = write | write_immediate;
   assign write_conflict = request && (busy_mask[write_index] || (load_write && load_index == write_index));
   assign accept         = request && !write_conflict;
   assign current        = regs[write_index];
   assign imm_type       = imm_type_t'(write_immediate_type);
   assign merged = write                   ? write_data :
                   imm_type == IT_TOP      ? {write_immediate_data, current[HW-1:0]} :
                   imm_type == IT_BOTTOM   ? {current[DATA_WIDTH-1:HW], write_immediate_data} :
                   imm_type == IT_SIGNED   ? {{HW{write_immediate_data[HW-1]}}, write_immediate_data} :
                                             {{HW{1'b0}}, write_immediate_data};
   // accepted ALU writes never share an index with a load, so both may commit together
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else begin
         if (accept) regs[write_index] <= merged;
         if (load_write) regs[load_index] <= load_data;
      end
   always_comb begin
      logic [IW-1:0] idx;
      read_data = '0;
      read_busy = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         idx = read_index[p*IW +: IW];
         read_data[p*DATA_WIDTH +: DATA_WIDTH] = (load_write && load_index == idx) ? load_data :
                                                 (accept && write_index == idx)    ? merged : regs[idx];
         read_busy[p] = !(load_write && load_index == idx) && busy_mask[idx];
      end
   end
endmodule

// File: tb/tb_scoreboard_register_file.sv
// tb_scoreboard_register_file: directed vector table, reset corner case and randomized run against a reference model.
module tb_scoreboard_register_file;
   import scoreboard_register_file_pkg::*;
   localparam int DW = 32, RC = 16, RP = 3, IW = 4, HW = 16;
   logic           clock = 0, reset = 0;
   logic           write = 0, write_immediate = 0, load_write = 0, reserve = 0;
   logic [IW-1:0]  write_index = 0, load_index = 0, reserve_index = 0;
   logic [DW-1:0]  write_data = 0, load_data = 0;
   logic [HW-1:0]  write_immediate_data = 0;
   logic [1:0]     write_immediate_type = 0;
   logic [RP*IW-1:0] read_index = 0;
   logic [RP*DW-1:0] read_data;
   logic [RP-1:0]  read_busy;
   logic [RC-1:0]  busy_mask;
   logic [IW:0]    busy_count;
   logic           reserve_conflict, write_conflict;
   scoreboard_register_file dut (
      .clock(clock), .reset(reset), .write(write), .write_immediate(write_immediate),
      .write_index(write_index), .write_data(write_data),
      .write_immediate_data(write_immediate_data), .write_immediate_type(write_immediate_type),
      .load_write(load_write), .load_index(load_index), .load_data(load_data),
      .reserve(reserve), .reserve_index(reserve_index), .read_index(read_index),
      .read_data(read_data), .read_busy(read_busy), .busy_mask(busy_mask),
      .busy_count(busy_count), .reserve_conflict(reserve_conflict), .write_conflict(write_conflict)
   );
   always #5 clock = ~clock;
   int checks = 0, fails = 0;
   // reference model: architectural contents and pending set
   logic [DW-1:0] mem [RC];
   logic [RC-1:0] mbusy = '0;
   logic [DW-1:0] e_rd [RP];
   logic          e_rb [RP];
   logic          e_wc, e_rc, e_acc;
   logic [DW-1:0] e_val;
   typedef struct {
      logic wr, wimm; logic [IW-1:0] wi; logic [DW-1:0] wd; logic [HW-1:0] imm; logic [1:0] it;
      logic lw; logic [IW-1:0] li; logic [DW-1:0] ld; logic rsv; logic [IW-1:0] ri, rdi;
      logic [DW-1:0] e_rd; logic e_rb, e_wc, e_rc; int e_cnt;
   } vec_t;
   vec_t tbl [16];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic void model_eval();
      logic [DW-1:0] old;
      int s;
      logic [IW-1:0] idx;
      e_wc  = (write | write_immediate) && (mbusy[write_index] || (load_write && load_index == write_index));
      e_acc = (write | write_immediate) && !e_wc;
      old = mem[write_index];
      s = $signed(write_immediate_data);
      if (write) e_val = write_data;
      else case (write_immediate_type)
         IT_TOP:    e_val = (32'(write_immediate_data) << 16) | (old & 32'h0000FFFF);
         IT_BOTTOM: e_val = (old & 32'hFFFF0000) | 32'(write_immediate_data);
         IT_SIGNED: e_val = s;
         default:   e_val = 32'(write_immediate_data);
      endcase
      e_rc = reserve && mbusy[reserve_index] && !(load_write && load_index == reserve_index);
      for (int p = 0; p < RP; p++) begin
         idx = read_index[p*IW +: IW];
         if (load_write && load_index == idx) begin e_rd[p] = load_data; e_rb[p] = 0; end
         else if (e_acc && write_index == idx) begin e_rd[p] = e_val; e_rb[p] = mbusy[idx]; end
         else begin e_rd[p] = mem[idx]; e_rb[p] = mbusy[idx]; end
      end
   endfunction
   function automatic void model_commit();
      if (e_acc) mem[write_index] = e_val;
      if (load_write) begin mem[load_index] = load_data; mbusy[load_index] = 0; end
      if (reserve && !e_rc) mbusy[reserve_index] = 1;
   endfunction
   function automatic void model_reset();
      for (int i = 0; i < RC; i++) mem[i] = '0;
      mbusy = '0;
   endfunction
   task automatic tick();
      model_eval();
      @(posedge clock);
      model_commit();
      #1;
   endtask
   task automatic idle();
      write = 0; write_immediate = 0; load_write = 0; reserve = 0;
   endtask
   task automatic check_all(input string tag);
      model_eval();
      for (int p = 0; p < RP; p++) begin
         chk($sformatf("%s read_data[%0d]", tag, p), read_data[p*DW +: DW], e_rd[p]);
         chk($sformatf("%s read_busy[%0d]", tag, p), read_busy[p], e_rb[p]);
      end
      chk({tag, " busy_mask"}, busy_mask, mbusy);
      chk({tag, " busy_count"}, busy_count, $countones(mbusy));
      chk({tag, " write_conflict"}, write_conflict, e_wc);
      chk({tag, " reserve_conflict"}, reserve_conflict, e_rc);
   endtask
   initial begin
      model_reset();
      tbl[0]  = '{0,1,3,0,'hABCD,IT_UNSIGNED,0,0,0,0,0,3,'h0000ABCD,0,0,0,0};
      tbl[1]  = '{0,1,3,0,'h1234,IT_TOP,0,0,0,0,0,3,'h1234ABCD,0,0,0,0};
      tbl[2]  = '{0,1,4,0,'h8001,IT_SIGNED,0,0,0,0,0,3,'h1234ABCD,0,0,0,0};
      tbl[3]  = '{0,0,0,0,0,0,0,0,0,0,0,4,'hFFFF8001,0,0,0,0};
      tbl[4]  = '{0,0,0,0,0,0,0,0,0,1,5,5,0,0,0,0,1};
      tbl[5]  = '{1,0,5,'h11,0,0,0,0,0,0,0,5,0,1,1,0,1};
      tbl[6]  = '{0,0,0,0,0,0,0,0,0,0,0,5,0,1,0,0,1};
      tbl[7]  = '{0,0,0,0,0,0,1,5,'h22,0,0,5,'h22,0,0,0,0};
      tbl[8]  = '{0,0,0,0,0,0,0,0,0,0,0,5,'h22,0,0,0,0};
      tbl[9]  = '{0,0,0,0,0,0,0,0,0,1,7,7,0,0,0,0,1};
      tbl[10] = '{0,0,0,0,0,0,0,0,0,1,7,7,0,1,0,1,1};
      tbl[11] = '{0,0,0,0,0,0,1,7,'h33,1,7,7,'h33,0,0,0,1};
      tbl[12] = '{0,0,0,0,0,0,0,0,0,0,0,7,'h33,1,0,0,1};
      tbl[13] = '{1,0,7,'h55,0,0,1,7,'h44,0,0,7,'h44,0,1,0,0};
      tbl[14] = '{0,1,3,0,'h7777,IT_BOTTOM,0,0,0,0,0,3,'h12347777,0,0,0,0};
      tbl[15] = '{0,0,0,0,0,0,0,0,0,0,0,7,'h44,0,0,0,0};
      // reset state
      read_index = {4'd15, 4'd5, 4'd0};
      #3;
      for (int p = 0; p < RP; p++) chk($sformatf("reset read_data[%0d]", p), read_data[p*DW +: DW], 0);
      chk("reset busy_mask", busy_mask, 0);
      chk("reset busy_count", busy_count, 0);
      #9 reset = 1;
      @(posedge clock); #1;
      // directed vectors
      foreach (tbl[i]) begin
         write = tbl[i].wr; write_immediate = tbl[i].wimm; write_index = tbl[i].wi; write_data = tbl[i].wd;
         write_immediate_data = tbl[i].imm; write_immediate_type = tbl[i].it;
         load_write = tbl[i].lw; load_index = tbl[i].li; load_data = tbl[i].ld;
         reserve = tbl[i].rsv; reserve_index = tbl[i].ri; read_index = {RP{tbl[i].rdi}};
         @(negedge clock);
         chk($sformatf("vec%0d read_data", i), read_data[DW-1:0], tbl[i].e_rd);
         chk($sformatf("vec%0d read_busy", i), read_busy[0], tbl[i].e_rb);
         chk($sformatf("vec%0d write_conflict", i), write_conflict, tbl[i].e_wc);
         chk($sformatf("vec%0d reserve_conflict", i), reserve_conflict, tbl[i].e_rc);
         tick();
         chk($sformatf("vec%0d busy_count", i), busy_count, tbl[i].e_cnt);
      end
      // reservations discarded by an asynchronous mid-cycle reset
      idle(); reserve = 1; reserve_index = 2; tick();
      reserve_index = 9; tick();
      idle();
      chk("pre-reset busy_mask", busy_mask, 16'h0204);
      read_index = {RP{4'd3}};
      #2 reset = 0;
      #1;
      model_reset();
      chk("async reset busy_mask", busy_mask, 0);
      chk("async reset busy_count", busy_count, 0);
      chk("async reset read_data", read_data[DW-1:0], 0);
      #2 reset = 1;
      @(posedge clock); #1;
      load_write = 1; load_index = 2; load_data = 32'h99; tick();
      idle(); read_index = {RP{4'd2}};
      #1;
      chk("post-reset load data", read_data[DW-1:0], 32'h99);
      chk("post-reset busy_count", busy_count, 0);
      // randomized run
      for (int n = 0; n < 400; n++) begin
         write = $urandom_range(0, 3) == 0;
         write_immediate = $urandom_range(0, 2) == 0;
         write_index = 4'($urandom);
         write_data = $urandom;
         write_immediate_data = 16'($urandom);
         write_immediate_type = 2'($urandom);
         load_write = $urandom_range(0, 2) == 0;
         load_index = (mbusy != 0 && $urandom_range(0, 1) == 1) ? 4'($clog2(mbusy + 1) - 1) : 4'($urandom);
         load_data = $urandom;
         reserve = $urandom_range(0, 2) == 0;
         reserve_index = 4'($urandom);
         read_index = 12'($urandom);
         if ($urandom_range(0, 4) == 0) read_index[IW-1:0] = write_index;
         if ($urandom_range(0, 4) == 0) read_index[2*IW-1:IW] = load_index;
         @(negedge clock);
         check_all($sformatf("rand%0d", n));
         @(posedge clock);
         model_commit();
         #1;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
